frame_fetch_ctrl: RTL and testbench

Read-side DMA sequencer for the system DDR2 `s_axi_dma` slave port of the processor subsystem. It fetches a framebuffer region line-by-line as AXI4 INCR bursts and streams the returned words to a downstream pixel pipeline through a valid/ready interface. Software programs base, words-per-line and line count, then pulses start; the block reports busy, done and a sticky error.

---
 rtl/frame_fetch_pkg.sv | 18 +
 rtl/frame_fetch_beats.sv | 39 +++
 rtl/frame_fetch_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_frame_fetch_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_fetch_pkg.sv
// Shared types and constants for the frame fetch DMA sequencer.
// The optional abort-on-error behaviour is enabled with FRAME_FETCH_ABORT_EN.
package frame_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } fetch_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/frame_fetch_beats.sv
// Burst length calculator: the smallest of the burst limit, the words still
// needed in the current line and the words left before the next 4 KB page.
module frame_fetch_beats
    import frame_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int MAX_BURST  = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  words_left,
    output logic [8:0]            beats
);

    localparam int CW = ((LEN_WIDTH > 11) ? LEN_WIDTH : 11) + 1;

    logic [12:0]   bytes_to_bnd;
    logic [CW-1:0] bnd_words;
    logic [CW-1:0] left_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] pick;

    // Three-way minimum, all operands widened to a common width first
    always_comb begin
        bytes_to_bnd = 13'(BOUNDARY_4K) - {1'b0, 12'(addr)};
        bnd_words    = CW'(bytes_to_bnd >> 2);
        left_w       = CW'(words_left);
        max_w        = CW'(MAX_BURST);
        pick         = max_w;
        if (left_w < pick) begin
            pick = left_w;
        end
        if (bnd_words < pick) begin
            pick = bnd_words;
        end
        beats = 9'(pick);
    end

endmodule

// File: rtl/frame_fetch_ctrl.sv
// Read-side DMA sequencer: fetches a framebuffer line by line as AXI4 INCR
// bursts and forwards the returned words to a valid/ready pixel stream.
// Define FRAME_FETCH_ABORT_EN to stop the frame after the first error beat.
module frame_fetch_ctrl
    import frame_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_line_words,
    input  logic [LEN_WIDTH-1:0]  cfg_lines,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_eol,
    output logic                  m_eof,
    input  logic                  m_ready
);

    fetch_state_t          state;
    fetch_state_t          state_next;

    logic [LEN_WIDTH-1:0]  line_words;
    logic [LEN_WIDTH-1:0]  line_left;
    logic [LEN_WIDTH-1:0]  lines_left;
    logic [8:0]            beat_cnt;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [LEN_WIDTH-1:0]  calc_words;
    logic [8:0]            calc_beats;

    logic                  beat_fire;
    logic                  last_beat;
    logic                  beat_err;
    logic                  frame_empty;
    logic                  more_words;
    logic                  more_lines;

`ifdef FRAME_FETCH_ABORT_EN
    logic                  aborting;
`endif

    assign beat_fire   = (state == DATA) && rvalid && rready;
    assign last_beat   = beat_fire && ((beat_cnt == 9'd1) || rlast);
    assign beat_err    = beat_fire && (rresp != AXI_RESP_OKAY);
    assign frame_empty = (cfg_line_words == '0) || (cfg_lines == '0);
    assign more_words  = (line_left != '0);
    assign more_lines  = (lines_left > LEN_WIDTH'(1));
    assign next_addr   = araddr + ((ADDR_WIDTH'(arlen) + ADDR_WIDTH'(1)) << 2);

    // Select the address and remaining length the next burst is sized from
    always_comb begin
        calc_addr  = next_addr;
        calc_words = line_left;
        if (state == IDLE) begin
            calc_addr  = cfg_base & ~ADDR_WIDTH'(3);
            calc_words = cfg_line_words;
        end else if (!more_words) begin
            calc_words = line_words;
        end
    end

    frame_fetch_beats #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_beats (
        .addr       (calc_addr),
        .words_left (calc_words),
        .beats      (calc_beats)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; the beat counter, not rlast alone, ends a burst
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = frame_empty ? DONE : ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (last_beat) begin
`ifdef FRAME_FETCH_ABORT_EN
                    state_next = (aborting || beat_err) ? DONE : NEXT;
`else
                    state_next = NEXT;
`endif
                end
            end
            NEXT: begin
                state_next = (more_words || more_lines) ? ADDR : DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame counters, burst address/length and the sticky error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            araddr     <= '0;
            arlen      <= '0;
            err        <= 1'b0;
            line_words <= '0;
            line_left  <= '0;
            lines_left <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (!frame_empty) begin
                            line_words <= cfg_line_words;
                            line_left  <= cfg_line_words;
                            lines_left <= cfg_lines;
                            araddr     <= calc_addr;
                            arlen      <= 8'(calc_beats - 9'd1);
                            beat_cnt   <= calc_beats;
                        end
                    end
                end
                DATA: begin
                    if (beat_fire) begin
                        beat_cnt  <= beat_cnt - 9'd1;
                        line_left <= line_left - LEN_WIDTH'(1);
                        if (beat_err) begin
                            err <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (more_words || more_lines) begin
                        araddr   <= calc_addr;
                        arlen    <= 8'(calc_beats - 9'd1);
                        beat_cnt <= calc_beats;
                        if (!more_words) begin
                            line_left  <= line_words;
                            lines_left <= lines_left - LEN_WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FRAME_FETCH_ABORT_EN
    // Once an error beat is seen the rest of the burst is drained silently
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aborting <= 1'b0;
        end else if (state == IDLE && start) begin
            aborting <= 1'b0;
        end else if (beat_err) begin
            aborting <= 1'b1;
        end
    end

    assign rready  = (state == DATA) && (aborting || m_ready);
    assign m_valid = (state == DATA) && !aborting && rvalid;
    assign m_eol   = (state == DATA) && !aborting && (line_left == LEN_WIDTH'(1));
`else
    assign rready  = (state == DATA) && m_ready;
    assign m_valid = (state == DATA) && rvalid;
    assign m_eol   = (state == DATA) && (line_left == LEN_WIDTH'(1));
`endif

    assign m_eof   = m_eol && (lines_left == LEN_WIDTH'(1));
    assign m_data  = rdata;
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign arvalid = (state == ADDR);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// Self-checking bench for frame_fetch_ctrl with an AXI read slave backed by
// an address-derived memory and a frame-level reference model.
module tb_frame_fetch_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 16;
    localparam int LW = 12;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [AW-1:0] cfg_base;
    logic [LW-1:0] cfg_line_words;
    logic [LW-1:0] cfg_lines;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_eol;
    logic          m_eof;
    logic          m_ready;

    int vectors    = 0;
    int miscompares = 0;

    frame_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .cfg_base       (cfg_base),
        .cfg_line_words (cfg_line_words),
        .cfg_lines      (cfg_lines),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_eol          (m_eol),
        .m_eof          (m_eof),
        .m_ready        (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ddr_word(input logic [31:0] a);
        return (a >> 2) + 32'h5A00_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame: builds the expected bursts and word stream from the
    // frame rules, plays AXI slave and stream sink, and checks everything.
    task automatic applyStimulus(input logic [31:0] base, input int lw, input int nl,
                                 input int err_idx, input int stall_max, input int mr_pct,
                                 input int rv_pct, input int poke_cyc, input int reset_cyc);
        logic [31:0] exp_addr[$];
        logic [7:0]  exp_len[$];
        int          exp_start[$];
        logic [31:0] a;
        logic [31:0] r_addr;
        logic [31:0] prev_addr;
        logic [7:0]  r_len;
        logic [7:0]  prev_len;
        int          left, b, bnd, acc, total, exp_words, exp_ars, budget;
        int          ar_wait, ar_count, m_idx, r_idx, glob_beat;
        bit          r_active, err_hit, done_seen, prev_stall, abort_mode;

`ifdef FRAME_FETCH_ABORT_EN
        abort_mode = 1'b1;
`else
        abort_mode = 1'b0;
`endif
        a     = base & ~32'd3;
        total = lw * nl;
        acc   = 0;
        if (total > 0) begin
            for (int l = 0; l < nl; l++) begin
                left = lw;
                while (left > 0) begin
                    b   = MB;
                    bnd = (4096 - int'(a[11:0])) / 4;
                    if (left < b) b = left;
                    if (bnd < b) b = bnd;
                    exp_addr.push_back(a);
                    exp_len.push_back(8'(b - 1));
                    exp_start.push_back(acc);
                    acc  += b;
                    a    += 32'(4 * b);
                    left -= b;
                end
            end
        end
        exp_words = total;
        if (abort_mode && err_idx >= 0 && err_idx < total) begin
            exp_words = err_idx + 1;
            while (exp_start.size() > 0 && exp_start[$] > err_idx) begin
                void'(exp_addr.pop_back());
                void'(exp_len.pop_back());
                void'(exp_start.pop_back());
            end
        end
        exp_ars = exp_addr.size();

        @(negedge clk);
        cfg_base       = base;
        cfg_line_words = LW'(lw);
        cfg_lines      = LW'(nl);
        start          = 1'b1;
        arready        = 1'b0;
        rvalid         = 1'b0;
        rlast          = 1'b0;
        rresp          = 2'b00;
        m_ready        = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("err_cleared", err, 0);
        if (total == 0) begin
            checkOutput("noop_done", done, 1);
            checkOutput("noop_busy", busy, 0);
        end else begin
            checkOutput("start_busy", busy, 1);
            checkOutput("start_arvalid", arvalid, 1);
        end

        ar_wait = -1; ar_count = 0; m_idx = 0; r_idx = 0; glob_beat = 0;
        r_active = 0; err_hit = 0; done_seen = 0; prev_stall = 0;
        r_addr = '0; r_len = '0; prev_addr = '0; prev_len = '0;
        budget = 300 + 12 * total + 20 * exp_ars;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (cyc == poke_cyc) begin
                start          = 1'b1;
                cfg_base       = $urandom;
                cfg_line_words = LW'($urandom);
                cfg_lines      = LW'($urandom);
            end else begin
                start = 1'b0;
            end
            if (arvalid) begin
                if (ar_wait < 0) ar_wait = $urandom_range(stall_max, 0);
                arready = (ar_wait == 0);
                if (ar_wait > 0) ar_wait--;
            end else begin
                arready = 1'($urandom_range(1, 0));
            end
            if (r_active) begin
                rvalid = ($urandom_range(99, 0) < rv_pct);
                rdata  = ddr_word(r_addr + 32'(4 * r_idx));
                rlast  = (r_idx == int'(r_len));
                rresp  = (glob_beat == err_idx) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                rdata  = $urandom;
            end
            m_ready = ($urandom_range(99, 0) < mr_pct);
            #1;

            if (reset_cyc >= 0 && cyc >= reset_cyc && r_active && r_idx > 0) begin
                resetn = 1'b0;
                #1;
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_done", done, 0);
                checkOutput("rst_arvalid", arvalid, 0);
                checkOutput("rst_rready", rready, 0);
                checkOutput("rst_m_valid", m_valid, 0);
                checkOutput("rst_araddr", araddr, 0);
                checkOutput("rst_arlen", arlen, 0);
                checkOutput("rst_err", err, 0);
                rvalid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                resetn = 1'b1;
                return;
            end

            if (done) begin
                done_seen = 1;
                break;
            end
            if (prev_stall) begin
                checkOutput("ar_hold_addr", araddr, prev_addr);
                checkOutput("ar_hold_len", arlen, prev_len);
            end
            if (r_active && !(abort_mode && err_hit)) begin
                checkOutput("rready_follows", rready, m_ready);
            end
            if (r_active && abort_mode && err_hit) begin
                checkOutput("drain_rready", rready, 1);
                checkOutput("drain_m_valid", m_valid, 0);
            end
            if (arvalid && arready) begin
                if (ar_count < exp_ars) begin
                    checkOutput("araddr", araddr, exp_addr[ar_count]);
                    checkOutput("arlen", arlen, exp_len[ar_count]);
                end else begin
                    checkOutput("ar_extra", ar_count + 1, exp_ars);
                end
                ar_count++;
                r_active = 1;
                r_addr   = araddr;
                r_len    = arlen;
                r_idx    = 0;
                ar_wait  = -1;
            end
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            prev_len   = arlen;
            if (m_valid && m_ready) begin
                if (m_idx < exp_words) begin
                    a = (base & ~32'd3) + 32'(4 * m_idx);
                    checkOutput("m_data", m_data, ddr_word(a));
                    checkOutput("m_eol", m_eol, ((m_idx + 1) % lw) == 0);
                    checkOutput("m_eof", m_eof, m_idx == total - 1);
                end else begin
                    checkOutput("m_extra", m_idx + 1, exp_words);
                end
                m_idx++;
            end
            if (rvalid && rready) begin
                if (glob_beat == err_idx) err_hit = 1;
                r_idx++;
                glob_beat++;
                if (r_idx > int'(r_len)) r_active = 0;
            end
        end
        start = 1'b0;

        checkOutput("done_pulse", done_seen, 1);
        checkOutput("ar_count", ar_count, exp_ars);
        checkOutput("word_count", m_idx, exp_words);
        checkOutput("err_flag", err, (err_idx >= 0 && err_idx < total));
        @(negedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("err_sticky", err, (err_idx >= 0 && err_idx < total));
    endtask

    initial begin
        logic [31:0] base;
        int          lw;
        int          nl;

        resetn         = 1'b0;
        start          = 1'b0;
        cfg_base       = '0;
        cfg_line_words = '0;
        cfg_lines      = '0;
        arready        = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        rlast          = 1'b0;
        rvalid         = 1'b0;
        m_ready        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_arvalid", arvalid, 0);
        checkOutput("reset_araddr", araddr, 0);
        checkOutput("reset_arlen", arlen, 0);
        checkOutput("const_arsize", arsize, 3'b010);
        checkOutput("const_arburst", arburst, 2'b01);
        @(negedge clk);
        resetn = 1'b1;

        $display("[TB] directed frame 0x1000 x40 x2");
        applyStimulus(32'h0000_1000, 40, 2, -1, 0, 100, 100, -1, -1);
        $display("[TB] 4 KB split frame");
        applyStimulus(32'h0000_0FF8, 8, 1, -1, 0, 100, 100, -1, -1);
        $display("[TB] address wrap frame");
        applyStimulus(32'hFFFF_FFF0, 8, 1, -1, 2, 70, 70, -1, -1);

        $display("[TB] randomized frames");
        for (int i = 0; i < 6; i++) begin
            base = 32'h1000 * $urandom_range(15, 0) + 32'(4 * $urandom_range(1023, 990));
            lw   = $urandom_range(70, 1);
            nl   = $urandom_range(3, 1);
            applyStimulus(base, lw, nl, -1, 5, 50, 70, -1, -1);
        end

        $display("[TB] error response on beat 3 of line 0");
        applyStimulus(32'h0000_2000, 40, 2, 2, 3, 50, 70, -1, -1);
        applyStimulus(32'h0000_3000, 20, 1, -1, 1, 80, 80, -1, -1);

        $display("[TB] empty frames");
        applyStimulus(32'h0000_4000, 8, 0, -1, 0, 100, 100, -1, -1);
        applyStimulus(32'h0000_4000, 0, 3, -1, 0, 100, 100, -1, -1);

        $display("[TB] start while busy");
        applyStimulus(32'h0000_5000, 24, 2, -1, 2, 60, 60, 10, -1);

        $display("[TB] reset during data phase");
        applyStimulus(32'h0000_6000, 40, 1, -1, 1, 80, 80, -1, 3);
        applyStimulus(32'h0000_6000, 40, 1, -1, 1, 80, 80, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
